// File: rtl/mcycle_core.sv
// mcycle_core: multicycle RV32I-subset core on a shared single-port BRAM with a byte TX port.
// Build option: define MCYCLE_CORE_MUL_EN to add the mul instruction.
module mcycle_core #(
  parameter int          ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0,
  parameter logic [31:0] GP_INIT  = 32'h200
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              memwe,
  output logic [ADDR_W-1:0] memaddr,
  output logic [31:0]       memdin,
  input  logic [31:0]       memdout,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [7:0]        a0out,
  output logic              halted
);
  localparam int PW = ADDR_W + 2;
  localparam logic [PW-1:0] PC_RST = PW'(RESET_PC);

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_TX     = 7'h7F;

  typedef enum logic [3:0] {
    S_F0, S_F1, S_DEC, S_EX, S_WB, S_MEM, S_LDW, S_TX, S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic [31:0]     ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d;
  logic [31:0]     rf_q [32];
  logic            rf_we;
  logic [4:0]      rf_wa;
  logic [31:0]     rf_wd;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_u, opb, alu_res;
  logic [PW-1:0] br_off, j_off, pc_plus4;
  logic        alt, legal, taken;

  assign opc      = ir_q[6:0];
  assign rd       = ir_q[11:7];
  assign f3       = ir_q[14:12];
  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign f7       = ir_q[31:25];
  assign imm_i    = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s    = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_u    = {ir_q[31:12], 12'h000};
  assign br_off   = PW'({{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0});
  assign j_off    = PW'({{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0});
  assign pc_plus4 = pc_q + PW'(4);

  always_comb begin
    legal = 1'b0;
    case (opc)
      OPC_LOAD, OPC_STORE: legal = (f3 == 3'b010);
      OPC_OPIMM: begin
        if (f3 == 3'b001)      legal = (f7 == 7'b0);
        else if (f3 == 3'b101) legal = (f7 == 7'b0) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
      end
      OPC_OP: begin
        legal = (f7 == 7'b0) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
`ifdef MCYCLE_CORE_MUL_EN
        if (f7 == 7'b0000001 && f3 == 3'b000) legal = 1'b1;
`endif
      end
      OPC_LUI, OPC_JAL, OPC_TX: legal = 1'b1;
      OPC_BRANCH: legal = (f3[2:1] != 2'b01);
      default: legal = 1'b0;
    endcase
  end

  // Immediate shifts only treat ir[30] as sub/sra select for funct3=101.
  always_comb begin
    opb = (opc == OPC_OP) ? b_q : imm_i;
    alt = ir_q[30] & ((opc == OPC_OP) | (f3 == 3'b101));
    case (f3)
      3'b000:  alu_res = alt ? a_q - opb : a_q + opb;
      3'b001:  alu_res = a_q << opb[4:0];
      3'b010:  alu_res = {31'b0, $signed(a_q) < $signed(opb)};
      3'b011:  alu_res = {31'b0, a_q < opb};
      3'b100:  alu_res = a_q ^ opb;
      3'b101:  alu_res = alt ? 32'($signed(a_q) >>> opb[4:0]) : a_q >> opb[4:0];
      3'b110:  alu_res = a_q | opb;
      default: alu_res = a_q & opb;
    endcase
`ifdef MCYCLE_CORE_MUL_EN
    if (opc == OPC_OP && f7 == 7'b0000001) alu_res = a_q * b_q;
`endif
    if (opc == OPC_LUI) alu_res = imm_u;
  end

  always_comb begin
    case (f3)
      3'b000:  taken = (a_q == b_q);
      3'b001:  taken = (a_q != b_q);
      3'b100:  taken = ($signed(a_q) < $signed(b_q));
      3'b101:  taken = !($signed(a_q) < $signed(b_q));
      3'b110:  taken = (a_q < b_q);
      3'b111:  taken = !(a_q < b_q);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    rf_we   = 1'b0;
    rf_wa   = rd;
    rf_wd   = alu_q;
    case (state_q)
      S_F0:  state_d = S_F1;
      S_F1: begin
        ir_d    = memdout;
        state_d = S_DEC;
      end
      S_DEC: begin
        a_d     = rf_q[rs1];
        b_d     = rf_q[rs2];
        state_d = legal ? S_EX : S_HALT;
      end
      S_EX: begin
        case (opc)
          OPC_LUI, OPC_OP, OPC_OPIMM: begin
            alu_d   = alu_res;
            state_d = S_WB;
          end
          OPC_LOAD: begin
            alu_d   = a_q + imm_i;
            state_d = S_MEM;
          end
          OPC_STORE: begin
            alu_d   = a_q + imm_s;
            state_d = S_MEM;
          end
          OPC_BRANCH: begin
            pc_d    = taken ? pc_q + br_off : pc_plus4;
            state_d = S_F0;
          end
          OPC_JAL: begin
            rf_we   = 1'b1;
            rf_wd   = 32'(pc_plus4);
            pc_d    = pc_q + j_off;
            state_d = S_F0;
          end
          OPC_TX:  state_d = S_TX;
          default: state_d = S_HALT;
        endcase
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_d    = pc_plus4;
        state_d = S_F0;
      end
      S_MEM: begin
        if (opc == OPC_STORE) begin
          pc_d    = pc_plus4;
          state_d = S_F0;
        end else begin
          state_d = S_LDW;
        end
      end
      S_LDW: begin
        rf_we   = 1'b1;
        rf_wd   = memdout;
        pc_d    = pc_plus4;
        state_d = S_F0;
      end
      S_TX: begin
        if (tx_ready) begin
          pc_d    = pc_plus4;
          state_d = S_F0;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_F0;
      pc_q    <= PC_RST;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= (i == 3) ? GP_INIT : 32'h0;
    end else if (rf_we && rf_wa != 5'd0) begin
      rf_q[rf_wa] <= rf_wd;
    end
  end

  assign memaddr  = (state_q == S_MEM) ? alu_q[PW-1:2] : pc_q[PW-1:2];
  assign memwe    = (state_q == S_MEM) && (opc == OPC_STORE);
  assign memdin   = b_q;
  assign tx_valid = (state_q == S_TX);
  assign tx_data  = a_q[7:0];
  assign a0out    = rf_q[10][7:0];
  assign halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_mcycle_core.sv
// Bench for mcycle_core: directed programs plus random straight-line programs checked
// against an instruction-level reference model, with a behavioural BRAM.
module tb_mcycle_core;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_REG   = 7'h33;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_TX    = 7'h7F;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        memwe;
  logic [7:0]  memaddr;
  logic [31:0] memdin;
  logic [31:0] memdout;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic [7:0]  a0out;
  logic        halted;

  logic [31:0] mem  [256];
  logic [31:0] prog [256];
  logic        tb_load = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mcycle_core #(.ADDR_W(8), .RESET_PC(0), .GP_INIT(32'h200)) dut (
    .clk(clk), .rstn(rstn), .memwe(memwe), .memaddr(memaddr), .memdin(memdin),
    .memdout(memdout), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .a0out(a0out), .halted(halted)
  );

  // Synchronous single-port RAM; a program image is copied in while tb_load is high.
  always @(posedge clk) begin
    if (tb_load) mem <= prog;
    else if (memwe) mem[memaddr] <= memdin;
    memdout <= mem[memaddr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd, input logic [6:0] opc);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), opc};
  endfunction
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] opc);
    logic [31:0] v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), opc};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], OP_STORE};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], OP_BR};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] v, input int rd);
    return {v[31:12], 5'(rd), OP_LUI};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), OP_JAL};
  endfunction

  // Reference ALU semantics via plain arithmetic (powers of two, two's complement).
  function automatic logic [31:0] alu_ref(input int f3, input bit alt,
                                          input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    p = 64'd1 << b[4:0];
    case (f3)
      0: return alt ? a + (~b + 32'd1) : a + b;
      1: return 32'(64'(a) * p);
      2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3: return (a < b) ? 32'd1 : 32'd0;
      4: return a ^ b;
      5: begin
        if (!alt || !a[31]) return 32'(64'(a) / p);
        return ~32'(64'(~a) / p);
      end
      6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic bit br_ref(input int f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      0: return a == b;
      1: return a != b;
      4: return int'(a) < int'(b);
      5: return int'(a) >= int'(b);
      6: return a < b;
      default: return a >= b;
    endcase
  endfunction

  logic [31:0] mr [32];
  logic [31:0] mm [256];
  int pcw, exp_cyc;

  task automatic wr_reg(input int rd, input logic [31:0] v);
    if (rd != 0) mr[rd] = v;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
  endtask

  task automatic emit_rand();
    int kind, rd, rs1, rs2, f3, sh, w;
    int bf [6];
    bit alt, tk;
    logic [31:0] a, b, res, u;
    logic [11:0] imm12;
    bf = '{0, 1, 4, 5, 6, 7};
    kind = $urandom_range(0, 9);
    rd   = $urandom_range(0, 31);
    rs1  = $urandom_range(0, 31);
    rs2  = $urandom_range(0, 31);
    f3   = $urandom_range(0, 7);
    a = mr[rs1];
    b = mr[rs2];
    if (kind <= 2) begin
      alt = (f3 == 0 || f3 == 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      prog[pcw] = enc_r(alt ? 32 : 0, rs2, rs1, f3, rd, OP_REG); pcw++;
      wr_reg(rd, alu_ref(f3, alt, a, b));
      exp_cyc += 5;
    end else if (kind <= 5) begin
      if (f3 == 1 || f3 == 5) begin
        sh  = $urandom_range(0, 31);
        alt = (f3 == 5) ? 1'($urandom_range(0, 1)) : 1'b0;
        prog[pcw] = enc_i((alt ? 32'h400 : 32'h0) | sh, rs1, f3, rd, OP_IMM);
        res = alu_ref(f3, alt, a, 32'(sh));
      end else begin
        imm12 = 12'($urandom);
        prog[pcw] = enc_i(int'(imm12), rs1, f3, rd, OP_IMM);
        res = alu_ref(f3, 1'b0, a, {{20{imm12[11]}}, imm12});
      end
      pcw++;
      wr_reg(rd, res);
      exp_cyc += 5;
    end else if (kind == 6) begin
      u = $urandom;
      prog[pcw] = enc_u(u, rd); pcw++;
      wr_reg(rd, {u[31:12], 12'h000});
      exp_cyc += 5;
    end else if (kind == 7) begin
      w = $urandom_range(160, 191);
      prog[pcw] = enc_i(w * 4, 0, 2, rd, OP_LOAD); pcw++;
      wr_reg(rd, mm[w]);
      exp_cyc += 6;
    end else if (kind == 8) begin
      w = $urandom_range(176, 191);
      prog[pcw] = enc_s(w * 4, rs2, 0, 2); pcw++;
      mm[w] = b;
      exp_cyc += 5;
    end else begin
      f3 = bf[$urandom_range(0, 5)];
      tk = br_ref(f3, a, b);
      prog[pcw] = enc_b(8, rs2, rs1, f3); pcw++;
      exp_cyc += 4;
      imm12 = 12'($urandom);
      prog[pcw] = enc_i(int'(imm12), rs1, 0, rd, OP_IMM); pcw++;
      if (!tk) begin
        wr_reg(rd, a + {{20{imm12[11]}}, imm12});
        exp_cyc += 5;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; tb_load = 1'b1;
    @(negedge clk);
    tb_load = 1'b0; rstn = 1'b1;
  endtask

  int r_cyc, r_we, r_we_cyc, r_txv, r_txd_bad, r_a0_chg;
  logic [7:0]  r_txd, r_we_addr;
  logic [31:0] r_we_data;

  // Runs until halted (bounded). ready_wait = cycles tx_ready stays low once tx_valid rises.
  task automatic run_prog(input string tag, input int budget, input int ready_wait);
    int run;
    logic [7:0] a0_init;
    run = 0; r_cyc = 0; r_we = 0; r_we_cyc = -1; r_txv = 0; r_txd_bad = 0; r_a0_chg = -1;
    r_txd = 8'h0; r_we_addr = 8'h0; r_we_data = 32'h0;
    a0_init = a0out;
    tx_ready = 1'b1;
    while (!halted && r_cyc < budget) begin
      @(posedge clk); #1;
      r_cyc++;
      if (memwe) begin
        r_we++; r_we_cyc = r_cyc; r_we_addr = memaddr; r_we_data = memdin;
      end
      if (tx_valid) begin
        if (run == 0) r_txd = tx_data;
        else if (tx_data !== r_txd) r_txd_bad++;
        run++; r_txv++;
        tx_ready = (run > ready_wait);
      end else begin
        run = 0;
        tx_ready = 1'b1;
      end
      if (r_a0_chg < 0 && a0out !== a0_init) r_a0_chg = r_cyc;
    end
    chk({tag, "_halt_reached"}, 32'(halted), 32'd1);
  endtask

  initial begin
    int k;

    // addi x10,x0,5 ; halt
    clear_prog();
    prog[0] = enc_i(5, 0, 0, 10, OP_IMM);
    do_reset();
    chk("rst_memwe",    32'(memwe),    32'd0);
    chk("rst_memaddr",  32'(memaddr),  32'd0);
    chk("rst_memdin",   memdin,        32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'd0);
    chk("rst_a0out",    32'(a0out),    32'd0);
    chk("rst_halted",   32'(halted),   32'd0);
    run_prog("addi", 50, 0);
    chk("addi_a0",       32'(a0out), 32'd5);
    chk("addi_a0_cycle", r_a0_chg,   32'd5);
    chk("addi_halt_cyc", r_cyc,      32'd8);
    chk("addi_no_we",    r_we,       32'd0);

    // sw x3,0(x3) ; lw x10,0(x3)
    clear_prog();
    prog[0] = enc_s(0, 3, 3, 2);
    prog[1] = enc_i(0, 3, 2, 10, OP_LOAD);
    do_reset();
    run_prog("swlw", 60, 0);
    chk("swlw_we_count", r_we,             32'd1);
    chk("swlw_we_cycle", r_we_cyc,         32'd4);
    chk("swlw_we_addr",  32'(r_we_addr),   32'h80);
    chk("swlw_we_data",  r_we_data,        32'h200);
    chk("swlw_mem",      mem[128],         32'h200);
    chk("swlw_a0",       32'(a0out),       32'h00);
    chk("swlw_halt_cyc", r_cyc,            32'd14);

    // counted loop with bne
    clear_prog();
    prog[0] = enc_i(3, 0, 0, 11, OP_IMM);
    prog[1] = enc_i(1, 10, 0, 10, OP_IMM);
    prog[2] = enc_b(-4, 11, 10, 1);
    do_reset();
    run_prog("loop", 100, 0);
    chk("loop_a0",       32'(a0out), 32'd3);
    chk("loop_halt_cyc", r_cyc,      32'd35);

    // TX with a 3-cycle ready stall, then one more instruction
    clear_prog();
    prog[0] = enc_i(32'h41, 0, 0, 10, OP_IMM);
    prog[1] = enc_i(0, 10, 0, 0, OP_TX);
    prog[2] = enc_i(7, 0, 0, 10, OP_IMM);
    do_reset();
    run_prog("tx", 80, 3);
    chk("tx_valid_cycles", r_txv,       32'd4);
    chk("tx_data_first",   32'(r_txd),  32'h41);
    chk("tx_data_stable",  r_txd_bad,   32'd0);
    chk("tx_a0_after",     32'(a0out),  32'd7);
    chk("tx_halt_cyc",     r_cyc,       32'd21);

    // backward branch from 0 wraps to the top word, pc+4 wraps back to 0
    clear_prog();
    prog[0]   = enc_b(-4, 0, 10, 0);
    prog[255] = enc_i(32'h5A, 0, 0, 10, OP_IMM);
    do_reset();
    run_prog("wrap", 60, 0);
    chk("wrap_a0",       32'(a0out), 32'h5A);
    chk("wrap_halt_cyc", r_cyc,      32'd16);

    // jal with link, then jal x0 as a plain jump
    clear_prog();
    prog[0] = enc_j(8, 1);
    prog[1] = enc_i(1, 0, 0, 10, OP_IMM);
    prog[2] = enc_i(9, 10, 0, 10, OP_IMM);
    prog[3] = enc_s(32'h300, 1, 0, 2);
    prog[4] = enc_j(8, 0);
    prog[5] = enc_i(32'h77, 0, 0, 10, OP_IMM);
    do_reset();
    run_prog("jal", 60, 0);
    chk("jal_a0",       32'(a0out), 32'd9);
    chk("jal_link",     mem[192],   32'd4);
    chk("jal_halt_cyc", r_cyc,      32'd21);

    // mul x10,x11,x12 with 7*6
    clear_prog();
    prog[0] = enc_i(7, 0, 0, 11, OP_IMM);
    prog[1] = enc_i(6, 0, 0, 12, OP_IMM);
    prog[2] = enc_r(1, 12, 11, 0, 10, OP_REG);
    do_reset();
    run_prog("mul", 60, 0);
`ifdef MCYCLE_CORE_MUL_EN
    chk("mul_a0",       32'(a0out), 32'd42);
    chk("mul_halt_cyc", r_cyc,      32'd18);
`else
    chk("mul_a0",       32'(a0out), 32'd0);
    chk("mul_halt_cyc", r_cyc,      32'd13);
`endif

    // reset while TX is stalled; the next image stores gp to check its reset value
    clear_prog();
    prog[0] = enc_i(32'h41, 0, 0, 10, OP_IMM);
    prog[1] = enc_i(0, 10, 0, 0, OP_TX);
    do_reset();
    tx_ready = 1'b0;
    k = 0;
    while (!tx_valid && k < 30) begin
      @(posedge clk); #1; k++;
    end
    chk("txrst_valid_seen", 32'(tx_valid), 32'd1);
    repeat (2) @(posedge clk);
    #1 chk("txrst_valid_held", 32'(tx_valid), 32'd1);
    clear_prog();
    prog[0] = enc_s(32'h3F0, 3, 0, 2);
    @(negedge clk);
    rstn = 1'b0; tb_load = 1'b1;
    @(posedge clk); #1;
    chk("txrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("txrst_memwe",    32'(memwe),    32'd0);
    chk("txrst_memaddr",  32'(memaddr),  32'd0);
    chk("txrst_a0",       32'(a0out),    32'd0);
    chk("txrst_halted",   32'(halted),   32'd0);
    @(negedge clk);
    tb_load = 1'b0; rstn = 1'b1;
    run_prog("txrst", 40, 0);
    chk("txrst_gp",       mem[252], 32'h200);
    chk("txrst_halt_cyc", r_cyc,    32'd8);

    // random straight-line programs with forward branch skips, then dump all registers
    for (int it = 0; it < 3; it++) begin
      clear_prog();
      for (int w = 160; w < 192; w++) prog[w] = $urandom;
      for (int w = 0; w < 256; w++) mm[w] = prog[w];
      for (int r = 0; r < 32; r++) mr[r] = 32'h0;
      mr[3] = 32'h200;
      pcw = 0;
      exp_cyc = 0;
      for (int n = 0; n < 40; n++) emit_rand();
      for (int r = 1; r < 32; r++) begin
        prog[pcw] = enc_s(896 + 4 * (r - 1), r, 0, 2); pcw++;
        mm[223 + r] = mr[r];
        exp_cyc += 5;
      end
      exp_cyc += 3;
      do_reset();
      run_prog($sformatf("rnd%0d", it), 3000, 0);
      chk($sformatf("rnd%0d_halt_cyc", it), r_cyc, exp_cyc);
      chk($sformatf("rnd%0d_a0", it), 32'(a0out), 32'(mr[10][7:0]));
      for (int w = 160; w < 255; w++) begin
        if (w < 192 || w >= 224)
          chk($sformatf("rnd%0d_mem%0d", it, w), mem[w], mm[w]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
